// File: rtl/bcd_pkg.sv
// Shared constants, handshake state type and per-digit helpers for the BCD counter chain.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic {
    HS_EMPTY = 1'b0,
    HS_FULL  = 1'b1
  } hs_state_e;

  function automatic logic [DIGIT_W-1:0] bcd_digit_to_gray(input logic [DIGIT_W-1:0] d);
    return d ^ (d >> 1);
  endfunction

  function automatic logic bcd_digit_valid(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Control and output-handshake bundle of the BCD counter chain.
// gray_out is present only when BCD_COUNTER_GRAY_OUT_EN is defined.
interface bcd_counter_chain_if #(parameter int NUM_DIGITS = 2);
  import bcd_pkg::*;

  localparam int W = DIGIT_W * NUM_DIGITS;

  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] bcd_out;
  logic         out_valid;
  logic         out_ready;
  logic         stall;
  logic         tc;
  logic         load_err;
  hs_state_e    hs_state;
`ifdef BCD_COUNTER_GRAY_OUT_EN
  logic [W-1:0] gray_out;
`endif

  // Handshake: bcd_out is accepted on any rising edge where out_valid && out_ready;
  // out_valid, once set, stays set with bcd_out stable until accepted or reloaded.
`ifdef BCD_COUNTER_GRAY_OUT_EN
  modport master (input en, up_dn, load, load_val, out_ready,
                  output bcd_out, out_valid, stall, tc, load_err, hs_state, gray_out);
  modport slave  (output en, up_dn, load, load_val, out_ready,
                  input bcd_out, out_valid, stall, tc, load_err, hs_state, gray_out);
`else
  modport master (input en, up_dn, load, load_val, out_ready,
                  output bcd_out, out_valid, stall, tc, load_err, hs_state);
  modport slave  (output en, up_dn, load, load_val, out_ready,
                  input bcd_out, out_valid, stall, tc, load_err, hs_state);
`endif

endinterface

// File: rtl/bcd_decade.sv
// One BCD decade register with wrap-around increment/decrement and parallel load.
// With BCD_COUNTER_GRAY_OUT_EN a Gray-coded copy is registered from the same next value.
module bcd_decade
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] digit,
`ifdef BCD_COUNTER_GRAY_OUT_EN
  output logic [DIGIT_W-1:0] gray,
`endif
  output logic               is_max,
  output logic               is_zero
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (inc) begin
      digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == '0) ? DIGIT_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

`ifdef BCD_COUNTER_GRAY_OUT_EN
  logic [DIGIT_W-1:0] gray_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gray_q <= '0;
    else     gray_q <= bcd_digit_to_gray(digit_d);
  end

  assign gray = gray_q;
`endif

  assign digit   = digit_q;
  assign is_max  = (digit_q == DIGIT_MAX);
  assign is_zero = (digit_q == '0);

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter with a valid/ready output stage.
// Optional Gray-coded output enabled by BCD_COUNTER_GRAY_OUT_EN.
module bcd_counter_chain
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  bcd_counter_chain_if.master bus
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  logic [W-1:0]          load_clean;
  logic [NUM_DIGITS-1:0] digit_bad;
  logic [NUM_DIGITS-1:0] is_max, is_zero;
  logic [NUM_DIGITS-1:0] carry, borrow;
  logic [NUM_DIGITS-1:0] inc, dec;
  logic                  advance;
  logic                  stall;
  logic                  load_err_q;
  hs_state_e             state_q, state_d;

  assign stall   = (state_q == HS_FULL) && !bus.out_ready;
  assign advance = bus.en && !bus.load && !stall;

  // Digit k moves only when every lower digit is at its wrap point.
  always_comb begin
    carry  = '0;
    borrow = '0;
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      carry[k]  = carry[k-1]  & is_max[k-1];
      borrow[k] = borrow[k-1] & is_zero[k-1];
    end
  end

  assign inc = {NUM_DIGITS{advance &  bus.up_dn}} & carry;
  assign dec = {NUM_DIGITS{advance & ~bus.up_dn}} & borrow;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [DIGIT_W-1:0] raw;
    assign raw                     = bus.load_val[k*DIGIT_W +: DIGIT_W];
    assign digit_bad[k]            = !bcd_digit_valid(raw);
    assign load_clean[k*DIGIT_W +: DIGIT_W] = digit_bad[k] ? '0 : raw;

    bcd_decade u_decade (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc[k]),
      .dec        (dec[k]),
      .load       (bus.load),
      .load_digit (load_clean[k*DIGIT_W +: DIGIT_W]),
      .digit      (bus.bcd_out[k*DIGIT_W +: DIGIT_W]),
`ifdef BCD_COUNTER_GRAY_OUT_EN
      .gray       (bus.gray_out[k*DIGIT_W +: DIGIT_W]),
`endif
      .is_max     (is_max[k]),
      .is_zero    (is_zero[k])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HS_EMPTY: if (bus.load || advance) state_d = HS_FULL;
      HS_FULL:  if (!bus.load && !advance && bus.out_ready) state_d = HS_EMPTY;
      default:  state_d = HS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HS_EMPTY;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_err_q <= bus.load && (|digit_bad);
    end
  end

  assign bus.out_valid = (state_q == HS_FULL);
  assign bus.stall     = stall;
  assign bus.tc        = bus.en && (bus.up_dn ? (&is_max) : (&is_zero));
  assign bus.load_err  = load_err_q;
  assign bus.hs_state  = state_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed self-checking bench for bcd_counter_chain with NUM_DIGITS = 2.
module tb_bcd_counter_chain;
  import bcd_pkg::*;

  localparam int ND = 2;
  localparam int W  = 4 * ND;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd_counter_chain_if #(.NUM_DIGITS(ND)) bus ();

  bcd_counter_chain #(.NUM_DIGITS(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers
  task automatic drive(input logic en, input logic up_dn, input logic load,
                       input logic [W-1:0] load_val, input logic out_ready);
    bus.en        = en;
    bus.up_dn     = up_dn;
    bus.load      = load;
    bus.load_val  = load_val;
    bus.out_ready = out_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checks++; if (bus.bcd_out !== 8'h00) begin errors++; $display("FAIL reset_bcd: got %h want 00", bus.bcd_out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", bus.load_err); end
    checks++; if (bus.stall !== 1'b0 || bus.tc !== 1'b0) begin errors++; $display("FAIL reset_stall_tc: got %b%b want 00", bus.stall, bus.tc); end
    checks++; if (bus.hs_state !== HS_EMPTY) begin errors++; $display("FAIL reset_state: got %0d want EMPTY", bus.hs_state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] exp_seq [3] = '{8'h99, 8'h00, 8'h01};
    logic         exp_tc  [3] = '{1'b1, 1'b0, 1'b0};
    drive(1'b0, 1'b1, 1'b1, 8'h98, 1'b1);
    tick();
    checks++; if (bus.bcd_out !== 8'h98 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL up_load: got %h/%b want 98/1", bus.bcd_out, bus.out_valid); end
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    #1;
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL up_tc_98: got %b want 0", bus.tc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.bcd_out !== exp_seq[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL up_step%0d: got %h/%b want %h/1", i, bus.bcd_out, bus.out_valid, exp_seq[i]); end
      checks++; if (bus.tc !== exp_tc[i]) begin errors++; $display("FAIL up_tc%0d: got %b want %b", i, bus.tc, exp_tc[i]); end
    end
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] exp_seq [3] = '{8'h00, 8'h99, 8'h98};
    logic         exp_tc  [3] = '{1'b1, 1'b0, 1'b0};
    drive(1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.bcd_out !== exp_seq[i]) begin errors++; $display("FAIL down_step%0d: got %h want %h", i, bus.bcd_out, exp_seq[i]); end
      checks++; if (bus.tc !== exp_tc[i]) begin errors++; $display("FAIL down_tc%0d: got %b want %b", i, bus.tc, exp_tc[i]); end
    end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b1, 1'b1, 8'h37, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.stall !== 1'b1 || bus.bcd_out !== 8'h37 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got stall=%b bcd=%h valid=%b want 1/37/1", i, bus.stall, bus.bcd_out, bus.out_valid); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL bp_release_stall: got %b want 0", bus.stall); end
    tick();
    checks++; if (bus.bcd_out !== 8'h38 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_resume: got %h/%b want 38/1", bus.bcd_out, bus.out_valid); end
    bus.en = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.bcd_out !== 8'h38 || bus.hs_state !== HS_EMPTY) begin errors++; $display("FAIL bp_accept: got %h/%b want 38/0", bus.bcd_out, bus.out_valid); end
    tick();
    checks++; if (bus.bcd_out !== 8'h38 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL en0_hold: got %h/%b want 38/0", bus.bcd_out, bus.out_valid); end
  endtask

  task automatic test_invalid_load();
    drive(1'b0, 1'b1, 1'b1, 8'h4A, 1'b1);
    tick();
    checks++; if (bus.bcd_out !== 8'h40 || bus.load_err !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bad_load: got %h err=%b valid=%b want 40/1/1", bus.bcd_out, bus.load_err, bus.out_valid); end
    bus.load_val = 8'h59;
    tick();
    checks++; if (bus.bcd_out !== 8'h59 || bus.load_err !== 1'b0) begin errors++; $display("FAIL good_load: got %h err=%b want 59/0", bus.bcd_out, bus.load_err); end
    bus.load_val = 8'hF3;
    tick();
    checks++; if (bus.bcd_out !== 8'h03 || bus.load_err !== 1'b1) begin errors++; $display("FAIL bad_hi_load: got %h err=%b want 03/1", bus.bcd_out, bus.load_err); end
    bus.load = 1'b0;
    tick();
    checks++; if (bus.load_err !== 1'b0 || bus.bcd_out !== 8'h03) begin errors++; $display("FAIL err_pulse_end: got %h err=%b want 03/0", bus.bcd_out, bus.load_err); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    tick();
    bus.load_val = 8'h22;
    tick();
    checks++; if (bus.bcd_out !== 8'h22 || bus.out_valid !== 1'b1 || bus.stall !== 1'b1) begin errors++; $display("FAIL overwrite: got %h valid=%b stall=%b want 22/1/1", bus.bcd_out, bus.out_valid, bus.stall); end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checks++; if (bus.bcd_out !== 8'h21 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL accept_and_step: got %h/%b want 21/1", bus.bcd_out, bus.out_valid); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h62, 1'b1);
    tick();
    bus.load = 1'b0;
    tick();
    checks++; if (bus.bcd_out !== 8'h63) begin errors++; $display("FAIL pre_reset: got %h want 63", bus.bcd_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.bcd_out !== 8'h00 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got %h/%b want 00/0", bus.bcd_out, bus.out_valid); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.bcd_out !== 8'h01 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL post_reset: got %h/%b want 01/1", bus.bcd_out, bus.out_valid); end
  endtask

`ifdef BCD_COUNTER_GRAY_OUT_EN
  task automatic test_gray();
    drive(1'b0, 1'b1, 1'b1, 8'h59, 1'b1);
    tick();
    checks++; if (bus.gray_out !== 8'h7D) begin errors++; $display("FAIL gray_59: got %h want 7d", bus.gray_out); end
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    checks++; if (bus.bcd_out !== 8'h60 || bus.gray_out !== 8'h50) begin errors++; $display("FAIL gray_60: got %h/%h want 60/50", bus.bcd_out, bus.gray_out); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_backpressure();
    test_invalid_load();
    test_back_to_back();
    test_async_reset();
`ifdef BCD_COUNTER_GRAY_OUT_EN
    test_gray();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
